// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: data width, default TX FIFO depth and control-bit indices.
package uart_tx_fifo_pkg;

   localparam int unsigned UART_DATA_W                = 8;
   localparam int unsigned UART_TX_FIFO_DEPTH_DEFAULT = 16;

   // Bit position of the TX level interrupt enable in the APB control register
   localparam int unsigned UART_CTRL_TX_LVL_IRQ_BIT   = 5;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_tx_fifo_pkg

// File: rtl/uart_fifo_mem.sv
// Simple dual-port byte array: synchronous write, asynchronous read.
// Shared by the TX and RX FIFOs; contents are intentionally not reset.
module uart_fifo_mem #(
   parameter  int unsigned DEPTH = 16,
   parameter  int unsigned W     = 8,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [W-1:0]  wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [W-1:0]  rd_data_c
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_c = mem_q[rd_addr_i];

endmodule : uart_fifo_mem

// File: rtl/uart_tx_fifo.sv
// TX byte FIFO between the APB data-register write path and the UART transmitter.
// First-word-fall-through read side, fill level, low watermark, sticky overflow, flush.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter  int unsigned DEPTH = UART_TX_FIFO_DEPTH_DEFAULT,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [UART_DATA_W-1:0] wr_data,
   output logic                   full,
   output logic                   empty,
   output logic [AW:0]            level,
   input  logic [AW:0]            thresh,
   output logic                   below_thresh,
   output logic                   ovfl,
   input  logic                   ovfl_clr,
   input  logic                   flush,
   input  logic                   en,
   output logic [UART_DATA_W-1:0] tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready
);

   localparam int unsigned CW = AW + 1;

   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   ovfl_q, ovfl_d;
   logic                   push, pop, mem_we;
   logic [UART_DATA_W-1:0] head_data;

   // Flags decode only from the count register, never from wr_en or tx_ready
   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign level        = count_q;
   assign below_thresh = (count_q <= thresh);
   assign ovfl         = ovfl_q;

   assign tx_valid = !empty && en;
   assign tx_data  = empty ? '0 : head_data;

   assign push   = wr_en && !full;
   assign pop    = tx_valid && tx_ready;
   assign mem_we = push && !flush;

   uart_fifo_mem #(
      .DEPTH (DEPTH),
      .W     (UART_DATA_W)
   ) u_mem (
      .clk       (clk),
      .wr_en_i   (mem_we),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (wr_data),
      .rd_addr_i (rd_ptr_q),
      .rd_data_c (head_data)
   );

   // Next-state for pointers, count and overflow; flush dominates push/pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovfl_d   = ovfl_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end

      // A rejected push in the same cycle as a clear keeps the flag set
      if (ovfl_clr) begin
         ovfl_d = 1'b0;
      end
      if (wr_en && full) begin
         ovfl_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovfl_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovfl_q   <= ovfl_d;
      end
   end

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          full, empty;
   logic [AW:0]   level;
   logic [AW:0]   thresh;
   logic          below_thresh;
   logic          ovfl;
   logic          ovfl_clr;
   logic          flush;
   logic          en;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: FIFO contents as a queue plus the sticky overflow bit
   logic [7:0] q[$];
   bit         ovfl_m = 1'b0;

   uart_tx_fifo #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .full         (full),
      .empty        (empty),
      .level        (level),
      .thresh       (thresh),
      .below_thresh (below_thresh),
      .ovfl         (ovfl),
      .ovfl_clr     (ovfl_clr),
      .flush        (flush),
      .en           (en),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   // Compare on the falling edge, then advance the model with the inputs the next rising edge samples
   always @(negedge clk) begin
      int sz;
      bit mfull;
      bit mpop;
      if (!rst_n) begin
         q.delete();
         ovfl_m = 1'b0;
      end
      sz = q.size();
      chk("level",        32'(level),        32'(sz));
      chk("full",         32'(full),         32'(sz == DEPTH));
      chk("empty",        32'(empty),        32'(sz == 0));
      chk("tx_valid",     32'(tx_valid),     32'(sz > 0 && en));
      chk("tx_data",      32'(tx_data),      32'(sz > 0 ? q[0] : 8'h00));
      chk("below_thresh", 32'(below_thresh), 32'(sz <= int'(thresh)));
      chk("ovfl",         32'(ovfl),         32'(ovfl_m));
      if (rst_n) begin
         mfull = (sz == DEPTH);
         mpop  = (sz > 0) && en && tx_ready;
         if (flush) begin
            q.delete();
         end else begin
            if (mpop) void'(q.pop_front());
            if (wr_en && !mfull) q.push_back(wr_data);
         end
         if (ovfl_clr) ovfl_m = 1'b0;
         if (wr_en && mfull) ovfl_m = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_seq(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         wr_en   = 1'b1;
         wr_data = base + 8'(i);
         tick();
      end
      wr_en = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      wr_en    = 1'b0;
      wr_data  = 8'h00;
      thresh   = 5'd2;
      ovfl_clr = 1'b0;
      flush    = 1'b0;
      en       = 1'b0;
      tx_ready = 1'b0;
      repeat (3) tick();
      chk("rst_level",  32'(level),        32'd0);
      chk("rst_empty",  32'(empty),        32'd1);
      chk("rst_below",  32'(below_thresh), 32'd1);
      chk("rst_txdata", 32'(tx_data),      32'h00);
      rst_n = 1'b1;
      tick();

      // Single byte: one-cycle latency, then a single pop
      en = 1'b1;
      wr_en = 1'b1; wr_data = 8'hA5;
      tick();
      wr_en = 1'b0;
      chk("t1_valid", 32'(tx_valid), 32'd1);
      chk("t1_data",  32'(tx_data),  32'hA5);
      chk("t1_level", 32'(level),    32'd1);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      chk("t1_drained", 32'(level), 32'd0);
      chk("t1_novalid", 32'(tx_valid), 32'd0);

      // Ordering, overflow and pointer wrap over three passes
      for (int rep = 0; rep < 3; rep++) begin
         push_seq(16, 8'h00);
         chk("t2_full",  32'(full),  32'd1);
         chk("t2_level", 32'(level), 32'd16);
         wr_en = 1'b1; wr_data = 8'hFF;
         tick();
         wr_en = 1'b0;
         chk("t2_ovfl",    32'(ovfl),  32'd1);
         chk("t2_level16", 32'(level), 32'd16);
         tx_ready = 1'b1;
         for (int i = 0; i < 16; i++) begin
            chk("t2_order", 32'(tx_data), 32'(i));
            tick();
         end
         tx_ready = 1'b0;
         chk("t2_empty", 32'(empty), 32'd1);
      end
      ovfl_clr = 1'b1;
      tick();
      ovfl_clr = 1'b0;
      chk("t2_ovfl_clr", 32'(ovfl), 32'd0);

      // Full with simultaneous push and pop: push rejected, pop proceeds
      push_seq(16, 8'h40);
      wr_en = 1'b1; wr_data = 8'h99; tx_ready = 1'b1;
      tick();
      wr_en = 1'b0; tx_ready = 1'b0;
      chk("t3_ovfl",  32'(ovfl),    32'd1);
      chk("t3_level", 32'(level),   32'd15);
      chk("t3_head",  32'(tx_data), 32'h41);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      // Empty with simultaneous push and ready: push lands, nothing popped
      wr_en = 1'b1; wr_data = 8'h3C; tx_ready = 1'b1;
      tick();
      wr_en = 1'b0; tx_ready = 1'b0;
      chk("t3_level1", 32'(level),   32'd1);
      chk("t3_head3c", 32'(tx_data), 32'h3C);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;

      // Low watermark crossing while draining from 6
      thresh = 5'd4;
      push_seq(6, 8'h60);
      tx_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("t4_level", 32'(level),        32'(6 - i));
         chk("t4_below", 32'(below_thresh), 32'((6 - i) <= 4));
         tick();
      end
      tx_ready = 1'b0;

      // en=0 holds contents; flush beats a concurrent push and leaves ovfl alone
      push_seq(5, 8'h50);
      en = 1'b0;
      tx_ready = 1'b1;
      #1;
      chk("t5_novalid", 32'(tx_valid), 32'd0);
      repeat (2) tick();
      chk("t5_level5", 32'(level), 32'd5);
      tx_ready = 1'b0;
      flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
      tick();
      flush = 1'b0; wr_en = 1'b0;
      chk("t5_level0", 32'(level), 32'd0);
      chk("t5_empty",  32'(empty), 32'd1);
      chk("t5_ovfl",   32'(ovfl),  32'd1);
      en = 1'b1;
      #1;
      chk("t5_discard", 32'(tx_valid), 32'd0);
      ovfl_clr = 1'b1;
      tick();
      ovfl_clr = 1'b0;

      // Asynchronous reset in the middle of a drain
      push_seq(3, 8'h21);
      tx_ready = 1'b1;
      tick();
      chk("t6_pre_valid", 32'(tx_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(tx_valid), 32'd0);
      chk("t6_rst_level", 32'(level),    32'd0);
      tx_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      wr_en = 1'b1; wr_data = 8'h11;
      tick();
      wr_en = 1'b0;
      chk("t6_valid", 32'(tx_valid), 32'd1);
      chk("t6_data",  32'(tx_data),  32'h11);
      chk("t6_level", 32'(level),    32'd1);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         wr_en    = ($urandom_range(0, 99) < 60);
         wr_data  = 8'($urandom);
         tx_ready = ($urandom_range(0, 99) < 50);
         en       = ($urandom_range(0, 99) < 85);
         ovfl_clr = ($urandom_range(0, 99) < 5);
         flush    = ($urandom_range(0, 99) < 2);
         if (flush) wr_en = 1'b0;
         if ($urandom_range(0, 199) == 0) thresh = 5'($urandom_range(0, 20));
         tick();
      end
      wr_en = 1'b0; tx_ready = 1'b0; flush = 1'b0; ovfl_clr = 1'b0;
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_uart_tx_fifo
